seg_scan_ctrl: RTL and testbench

Time-multiplexed scan controller for a bank of common-anode 7-segment digits sharing one segment bus. It holds a frame of NDIG hex nibbles and cycles through the digits, driving one anode at a time. Each nibble goes through a single shared driver7seg decoder. New frames arrive via a load/ready handshake and are committed only at a frame boundary, so the display never tears.

---
 rtl/seg_pkg.sv | 22 ++
 rtl/driver7seg.sv | 30 +++
 rtl/seg_scan_ctrl.sv | 159 +++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared types and constants for the multiplexed 7-segment scan controller.
package seg_pkg;

  localparam int unsigned MAX_DIG = 8;
  localparam logic [6:0]  SEG_BLANK = 7'h7F;

  typedef enum logic {
    S_GUARD = 1'b0,
    S_SHOW  = 1'b1
  } scan_state_e;

  // All-anodes-off pattern (active-low) for an n-digit bank, LSB aligned.
  function automatic logic [MAX_DIG-1:0] anode_off(input int unsigned n);
    logic [MAX_DIG-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < MAX_DIG; i++) begin
      if (i < n) r[i] = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/driver7seg.sv
// Hex nibble to active-low 7-segment pattern, bit order {g,f,e,d,c,b,a}.
module driver7seg (
  input  logic [3:0] nib,
  output logic [6:0] seg_c
);

  always_comb begin
    seg_c = 7'h7F;
    unique case (nib)
      4'h0: seg_c = 7'h40;
      4'h1: seg_c = 7'h79;
      4'h2: seg_c = 7'h24;
      4'h3: seg_c = 7'h30;
      4'h4: seg_c = 7'h19;
      4'h5: seg_c = 7'h12;
      4'h6: seg_c = 7'h02;
      4'h7: seg_c = 7'h78;
      4'h8: seg_c = 7'h00;
      4'h9: seg_c = 7'h10;
      4'hA: seg_c = 7'h08;
      4'hB: seg_c = 7'h03;
      4'hC: seg_c = 7'h46;
      4'hD: seg_c = 7'h21;
      4'hE: seg_c = 7'h06;
      4'hF: seg_c = 7'h0E;
      default: seg_c = 7'h7F;
    endcase
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for NDIG common-anode digits on one segment bus;
// new frames are staged and swapped in only at a frame boundary.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int unsigned NDIG     = 4,
  parameter int unsigned PRESCALE = 50000,
  parameter int unsigned GUARD    = 500
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              load,
  output logic              ready,
  input  logic [4*NDIG-1:0] data,
  input  logic [NDIG-1:0]   dp_in,
  input  logic              lz_en,
  output logic [6:0]        hex,
  output logic              dp,
  output logic [NDIG-1:0]   an
);

  localparam int unsigned CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned IW = (NDIG > 2) ? $clog2(NDIG) : 1;
  localparam logic [NDIG-1:0] AN_OFF = NDIG'(anode_off(NDIG));

  generate
    if (NDIG < 2 || NDIG > MAX_DIG) begin : g_bad_ndig
      $error("seg_scan_ctrl: NDIG must be 2..8");
    end
    if (PRESCALE < 4) begin : g_bad_prescale
      $error("seg_scan_ctrl: PRESCALE must be >= 4");
    end
    if (GUARD < 1 || GUARD >= PRESCALE - 1) begin : g_bad_guard
      $error("seg_scan_ctrl: GUARD must be 1..PRESCALE-2");
    end
  endgenerate

  scan_state_e state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [IW-1:0] idx, idx_n;

  logic [NDIG-1:0][3:0] disp, stag;
  logic [NDIG-1:0]      disp_dp, stag_dp;
  logic                 pending;

  logic slot_end_c, frame_end_c;
  logic [3:0] nib_c;
  logic [6:0] seg_c;
  logic [NDIG-1:0] zero_from_c;
  logic lz_blank_c;

  logic [NDIG-1:0] an_d;
  logic [6:0]      hex_d;
  logic            dp_d;

  assign slot_end_c  = en && (cnt == CW'(PRESCALE - 1));
  assign frame_end_c = slot_end_c && (idx == IW'(NDIG - 1));

  // State register: FSM, slot counter and digit index advance together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_GUARD;
      cnt   <= '0;
      idx   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
    end
  end

  // Next-state: guard until cnt reaches GUARD, show to slot end, then next digit.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    if (en) begin
      if (slot_end_c) begin
        cnt_n   = '0;
        state_n = S_GUARD;
        idx_n   = (idx == IW'(NDIG - 1)) ? '0 : idx + IW'(1);
      end else begin
        cnt_n = cnt + CW'(1);
        if (cnt == CW'(GUARD - 1)) state_n = S_SHOW;
      end
    end
  end

  // Staging/display registers and the load handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      disp    <= '0;
      disp_dp <= '0;
      stag    <= '0;
      stag_dp <= '0;
      pending <= 1'b0;
      ready   <= 1'b1;
    end else begin
      if (frame_end_c && pending) begin
        disp    <= stag;
        disp_dp <= stag_dp;
        pending <= 1'b0;
        ready   <= 1'b1;
      end
      if (load && ready) begin
        stag    <= data;
        stag_dp <= dp_in;
        pending <= 1'b1;
        ready   <= 1'b0;
      end
    end
  end

  assign nib_c = disp[idx];

  driver7seg u_dec (
    .nib   (nib_c),
    .seg_c (seg_c)
  );

  // zero_from_c[i]: every digit at position i and above is zero.
  always_comb begin
    logic acc;
    acc         = 1'b1;
    zero_from_c = '0;
    for (int i = int'(NDIG) - 1; i >= 0; i--) begin
      acc            = acc && (disp[i] == 4'h0);
      zero_from_c[i] = acc;
    end
  end

  assign lz_blank_c = lz_en && (idx != '0) && zero_from_c[idx] && !disp_dp[idx];

  // Output decode; anode stays asserted for a suppressed digit.
  always_comb begin
    an_d  = AN_OFF;
    hex_d = SEG_BLANK;
    dp_d  = 1'b1;
    if (en && state == S_SHOW) begin
      an_d[idx] = 1'b0;
      hex_d     = lz_blank_c ? SEG_BLANK : seg_c;
      dp_d      = ~disp_dp[idx];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an  <= AN_OFF;
      hex <= SEG_BLANK;
      dp  <= 1'b1;
    end else begin
      an  <= an_d;
      hex <= hex_d;
      dp  <= dp_d;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Randomised bench for seg_scan_ctrl against a frame-position behavioural model.
module tb_seg_scan_ctrl;

  localparam int NDIG = 4;
  localparam int PRESCALE = 8;
  localparam int GUARD = 2;
  localparam int FRAME = NDIG * PRESCALE;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b1;
  logic load = 1'b0;
  logic [15:0] data = '0;
  logic [3:0] dp_in = '0;
  logic lz_en = 1'b0;
  logic ready;
  logic [6:0] hex;
  logic dp;
  logic [3:0] an;

  int checks = 0;
  int errors = 0;

  seg_scan_ctrl #(.NDIG(NDIG), .PRESCALE(PRESCALE), .GUARD(GUARD)) dut (
    .clk(clk), .rst(rst), .en(en), .load(load), .ready(ready),
    .data(data), .dp_in(dp_in), .lz_en(lz_en),
    .hex(hex), .dp(dp), .an(an)
  );

  always #5 clk = ~clk;

  logic [6:0] segtab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Model state: position within the frame, committed and staged frames.
  int pos = 0;
  logic [15:0] m_disp = '0, m_stag = '0;
  logic [3:0] m_ddp = '0, m_sdp = '0;
  bit m_pend = 0;
  logic [3:0] e_an = 4'hF;
  logic [6:0] e_hex = 7'h7F;
  logic e_dp = 1'b1, e_rdy = 1'b1;

  task automatic model_step();
    int cnt, id;
    bit blank, pend_pre;
    if (rst) begin
      pos = 0; m_disp = '0; m_stag = '0; m_ddp = '0; m_sdp = '0; m_pend = 0;
      e_an = 4'hF; e_hex = 7'h7F; e_dp = 1'b1; e_rdy = 1'b1;
      return;
    end
    cnt = pos % PRESCALE;
    id  = pos / PRESCALE;
    e_an = 4'hF; e_hex = 7'h7F; e_dp = 1'b1;
    if (en && cnt >= GUARD) begin
      e_an[id] = 1'b0;
      blank = lz_en && id > 0 && !m_ddp[id];
      for (int j = id; j < NDIG; j++) if (m_disp[4*j +: 4] != 4'h0) blank = 0;
      e_hex = blank ? 7'h7F : segtab[m_disp[4*id +: 4]];
      e_dp = ~m_ddp[id];
    end
    pend_pre = m_pend;
    if (en && pos == FRAME - 1 && pend_pre) begin
      m_disp = m_stag; m_ddp = m_sdp; m_pend = 0;
    end
    if (load && !pend_pre) begin
      m_stag = data; m_sdp = dp_in; m_pend = 1;
    end
    if (en) pos = (pos + 1) % FRAME;
    e_rdy = !m_pend;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle compare of every output against the model.
  initial forever begin
    @(negedge clk);
    if (rst) begin
      chk("an_rst", 32'(an), 32'hF);
      chk("hex_rst", 32'(hex), 32'h7F);
      chk("dp_rst", 32'(dp), 32'h1);
      chk("ready_rst", 32'(ready), 32'h1);
    end else begin
      chk("an", 32'(an), 32'(e_an));
      chk("hex", 32'(hex), 32'(e_hex));
      chk("dp", 32'(dp), 32'(e_dp));
      chk("ready", 32'(ready), 32'(e_rdy));
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Wait (on negedges) for a given anode pattern, bounded.
  task automatic wait_an(input logic [3:0] t, input string nm);
    int n = 0;
    do begin @(negedge clk); n++; end while (an !== t && n < 300);
    if (an !== t) chk({nm, "_timeout"}, 32'(an), 32'(t));
  endtask

  task automatic wait_ready(input string nm);
    int n = 0;
    do begin @(negedge clk); n++; end while (ready !== 1'b1 && n < 300);
    if (ready !== 1'b1) chk({nm, "_timeout"}, 32'(ready), 32'h1);
  endtask

  task automatic digit_lit(input logic [3:0] a, input logic [6:0] h, input string nm);
    wait_an(a, nm);
    chk(nm, 32'(hex), 32'(h));
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] p);
    load = 1'b1; data = d; dp_in = p;
    step(1);
    load = 1'b0;
  endtask

  initial begin : stim
    int n;
    #1;
    step(3);
    rst = 1'b0;
    @(negedge clk);
    chk("lit_reset_ready", 32'(ready), 32'h1);
    chk("lit_reset_an", 32'(an), 32'hF);

    // Idle frame shows zeros on digit 0.
    digit_lit(4'b1110, 7'b1000000, "lit_idle_d0");
    digit_lit(4'b0111, 7'b1000000, "lit_idle_d3");
    @(posedge clk); #1;

    // Mid-frame load, then an ignored second load.
    step(5);
    do_load(16'h12AF, 4'b0001);
    @(negedge clk);
    chk("lit_ready_drop", 32'(ready), 32'h0);
    @(posedge clk); #1;
    do_load(16'hFFFF, 4'b1111);
    wait_ready("commit1");
    digit_lit(4'b1110, 7'b0001110, "lit_12af_d0");
    chk("lit_12af_dp0", 32'(dp), 32'h0);
    digit_lit(4'b1101, 7'b0001000, "lit_12af_d1");
    chk("lit_12af_dp1", 32'(dp), 32'h1);
    digit_lit(4'b1011, 7'b0100100, "lit_12af_d2");
    digit_lit(4'b0111, 7'b1111001, "lit_12af_d3");
    @(posedge clk); #1;

    // Load coincident with frame_end commits a full frame later.
    n = 0;
    while (pos != FRAME - 1 && n < 100) begin step(1); n++; end
    do_load(16'h3456, 4'b0000);
    n = 0;
    do begin step(1); n++; end while (ready !== 1'b1 && n < 100);
    chk("lit_coincident_latency", 32'(n), 32'd32);

    // Leading-zero suppression.
    lz_en = 1'b1;
    step(3);
    do_load(16'h0050, 4'b0000);
    wait_ready("commit_lz");
    digit_lit(4'b1110, 7'b1000000, "lit_lz_d0");
    digit_lit(4'b1101, 7'b0010010, "lit_lz_d1");
    digit_lit(4'b1011, 7'h7F, "lit_lz_d2");
    digit_lit(4'b0111, 7'h7F, "lit_lz_d3");
    @(posedge clk); #1;
    do_load(16'h0000, 4'b0000);
    wait_ready("commit_zero");
    digit_lit(4'b1110, 7'b1000000, "lit_zero_d0");
    digit_lit(4'b1101, 7'h7F, "lit_zero_d1");
    @(posedge clk); #1;
    lz_en = 1'b0;

    // Enable hold mid-SHOW, then reset with a pending frame.
    wait_an(4'b1101, "en_wait");
    @(posedge clk); #1;
    en = 1'b0;
    step(2);
    @(negedge clk);
    chk("lit_en0_an", 32'(an), 32'hF);
    @(posedge clk); #1;
    step(2);
    en = 1'b1;
    step(4);
    do_load(16'h9999, 4'b1010);
    rst = 1'b1;
    #1;
    chk("lit_rst_ready", 32'(ready), 32'h1);
    chk("lit_rst_an", 32'(an), 32'hF);
    chk("lit_rst_hex", 32'(hex), 32'h7F);
    step(1);
    rst = 1'b0;
    step(2 * FRAME);

    // Randomised traffic.
    for (int c = 0; c < 3000; c++) begin
      load  = ($urandom_range(0, 5) == 0);
      data  = 16'($urandom) >> (4 * $urandom_range(0, 4));
      dp_in = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      en    = ($urandom_range(0, 19) != 0);
      if ($urandom_range(0, 149) == 0) lz_en = ~lz_en;
      if ($urandom_range(0, 699) == 0) begin
        rst = 1'b1;
        step(1);
        rst = 1'b0;
      end else begin
        step(1);
      end
    end
    load = 1'b0;
    step(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
